// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package instr_fetch_ctrl_pkg;

  localparam int INST_W = 32;
  localparam int PC_W   = 32;

  localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Fetch sequencer states
  typedef enum logic {
    ST_FETCH  = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_e;

  // One buffered instruction together with the word address it came from
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] instr;
  } fetch_entry_t;

  // Next sequential PC; wraps naturally from 32'hFFFF_FFFF to 0
  function automatic logic [PC_W-1:0] pc_incr(input logic [PC_W-1:0] pc);
    return pc + 32'd1;
  endfunction

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// ROM read port and decode handshake bundled between fetch and its neighbours.
interface instr_fetch_ctrl_if #(
  parameter int AW = 10
);
  import instr_fetch_ctrl_pkg::*;

  logic                mem_en;
  logic [AW-1:0]       mem_addr;
  logic [INST_W-1:0]   mem_rdata;
  logic                inst_valid;
  logic                inst_ready;
  logic [INST_W-1:0]   inst_out;
  logic [PC_W-1:0]     inst_pc;

  // Fetch sequencer side
  modport master (
    output mem_en,
    output mem_addr,
    input  mem_rdata,
    output inst_valid,
    input  inst_ready,
    output inst_out,
    output inst_pc
  );

  // ROM wrapper / decode side
  modport slave (
    input  mem_en,
    input  mem_addr,
    output mem_rdata,
    input  inst_valid,
    output inst_ready,
    input  inst_out,
    input  inst_pc
  );

endinterface

// File: rtl/instr_fetch_ctrl_skid_buf.sv
// One-entry {pc, instr} skid buffer with push/pop/flush.
// Only the occupancy flag is reset; the payload is meaningless while empty.
module instr_fetch_ctrl_skid_buf
  import instr_fetch_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic         full,
  output fetch_entry_t dout
);

  logic         full_q, full_d;
  fetch_entry_t data_q, data_d;

  // Next occupancy and payload; flush dominates, push and pop never coincide
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (flush) begin
      full_d = 1'b0;
    end else if (push) begin
      full_d = 1'b1;
      data_d = din;
    end else if (pop) begin
      full_d = 1'b0;
    end
  end

  // Occupancy flag register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full_q <= 1'b0;
    end else begin
      full_q <= full_d;
    end
  end

  // Payload register
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign full = full_q;
  assign dout = data_q;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues reads to the 1-cycle synchronous ROM,
// and presents instructions to decode through a registered valid/ready stage
// backed by a one-entry skid buffer. Handles redirect (squash) and halt.
module instr_fetch_ctrl
  import instr_fetch_ctrl_pkg::*;
#(
  parameter int              AW       = 10,
  parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC
)(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  redirect_valid,
  input  logic [PC_W-1:0]       redirect_pc,
  input  logic                  halt_req,
  instr_fetch_ctrl_if.master    bus
);

  fetch_state_e      state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              rd_pending_q, rd_pending_d;
  logic [PC_W-1:0]   rd_pc_q, rd_pc_d;
  logic              inst_valid_q, inst_valid_d;
  logic [INST_W-1:0] inst_out_q, inst_out_d;
  logic [PC_W-1:0]   inst_pc_q, inst_pc_d;

  logic              issue;
  logic              out_free;
  logic              stalled_return;
  logic              skid_push, skid_pop, skid_flush, skid_full;
  fetch_entry_t      skid_din, skid_dout;

  // A returning read that cannot land anywhere but the skid blocks a new
  // issue, so the skid never has to absorb two entries.
  assign out_free       = !inst_valid_q || bus.inst_ready;
  assign stalled_return = rd_pending_q && inst_valid_q && !bus.inst_ready;

  // FSM next state and read-issue decision
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    if (redirect_valid) begin
      state_d = ST_FETCH;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (halt_req) begin
            state_d = ST_HALTED;
          end else begin
            issue = !skid_full && !stalled_return;
          end
        end
        ST_HALTED: begin
          state_d = ST_HALTED;
        end
        default: begin
          state_d = ST_FETCH;
        end
      endcase
    end
  end

  // PC, read tracking, output stage and skid control
  always_comb begin
    pc_d         = pc_q;
    rd_pending_d = 1'b0;
    rd_pc_d      = rd_pc_q;
    inst_valid_d = inst_valid_q;
    inst_out_d   = inst_out_q;
    inst_pc_d    = inst_pc_q;
    skid_push    = 1'b0;
    skid_pop     = 1'b0;
    skid_flush   = 1'b0;
    if (redirect_valid) begin
      // Squash everything: the in-flight return is simply ignored next cycle
      pc_d         = redirect_pc;
      inst_valid_d = 1'b0;
      skid_flush   = 1'b1;
    end else begin
      if (issue) begin
        rd_pending_d = 1'b1;
        rd_pc_d      = pc_q;
        pc_d         = pc_incr(pc_q);
      end
      if (out_free) begin
        // The skid always holds the oldest entry, so it drains first
        if (skid_full) begin
          inst_valid_d = 1'b1;
          inst_out_d   = skid_dout.instr;
          inst_pc_d    = skid_dout.pc;
          skid_pop     = 1'b1;
        end else if (rd_pending_q) begin
          inst_valid_d = 1'b1;
          inst_out_d   = bus.mem_rdata;
          inst_pc_d    = rd_pc_q;
        end else begin
          inst_valid_d = 1'b0;
        end
      end else if (rd_pending_q) begin
        skid_push = 1'b1;
      end
    end
  end

  // Control and output registers; outputs clear as soon as reset asserts
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_FETCH;
      pc_q         <= RESET_PC;
      rd_pending_q <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_out_q   <= '0;
      inst_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      rd_pending_q <= rd_pending_d;
      inst_valid_q <= inst_valid_d;
      inst_out_q   <= inst_out_d;
      inst_pc_q    <= inst_pc_d;
    end
  end

  // Address of the read in flight; only consulted while rd_pending_q is set
  always_ff @(posedge clk) begin
    rd_pc_q <= rd_pc_d;
  end

  assign skid_din = '{pc: rd_pc_q, instr: bus.mem_rdata};

  instr_fetch_ctrl_skid_buf u_skid (
    .clk   (clk),
    .reset (reset),
    .push  (skid_push),
    .pop   (skid_pop),
    .flush (skid_flush),
    .din   (skid_din),
    .full  (skid_full),
    .dout  (skid_dout)
  );

  // mem_en is forced low while reset is held, independent of the clock
  assign bus.mem_en     = issue && reset;
  assign bus.mem_addr   = pc_q[AW-1:0];
  assign bus.inst_valid = inst_valid_q;
  assign bus.inst_out   = inst_out_q;
  assign bus.inst_pc    = inst_pc_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: cycle table, hand-written reset corner,
// and a randomized run checked against a transaction-level stream model.
module tb_instr_fetch_ctrl;

  localparam int AW = 10;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;

  int n_vec = 0;
  int n_bad = 0;

  instr_fetch_ctrl_if #(.AW(AW)) bus ();

  instr_fetch_ctrl #(.AW(AW), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .bus            (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Distinct, nonzero content for every ROM word
  function automatic logic [31:0] rom_word(input logic [AW-1:0] a);
    return {a, 6'h2A, ~a, 6'h15};
  endfunction

  // Synchronous ROM model; junk on the bus when no read was issued
  always @(posedge clk) begin
    if (bus.mem_en) bus.mem_rdata <= rom_word(bus.mem_addr);
    else            bus.mem_rdata <= 32'hDEAD_BEEF;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply inputs for one cycle, then sample just before the rising edge
  task automatic drive(input logic rst, input logic rv, input logic [31:0] rpc,
                       input logic hlt, input logic rdy);
    @(negedge clk);
    rst_n          = rst;
    redirect_valid = rv;
    redirect_pc    = rpc;
    halt_req       = hlt;
    bus.inst_ready = rdy;
    #4;
  endtask

  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] rpc;
    logic        hlt;
    logic        rdy;
    logic        exp_en;
    logic [9:0]  exp_addr;
    logic        exp_iv;
    logic [31:0] exp_ipc;
  } vec_t;

  vec_t vecs[$];

  task automatic addv(input logic rst, input logic rv, input logic [31:0] rpc,
                      input logic hlt, input logic rdy, input logic en,
                      input logic [9:0] addr, input logic iv, input logic [31:0] ipc);
    vec_t v;
    v.rst = rst; v.rv = rv; v.rpc = rpc; v.hlt = hlt; v.rdy = rdy;
    v.exp_en = en; v.exp_addr = addr; v.exp_iv = iv; v.exp_ipc = ipc;
    vecs.push_back(v);
  endtask

  // Randomized-phase stream model
  logic [31:0] exp_issue_pc;
  logic [31:0] exp_deliver_pc;
  logic        model_halted;
  logic        prev_stall;
  logic [31:0] prev_ipc;
  logic [31:0] prev_iout;
  int          delivered;

  initial begin
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    halt_req       = 1'b0;
    bus.inst_ready = 1'b0;

    //    rst rv rpc           hlt rdy | en addr    iv ipc
    addv(0, 0, 32'h0,        0, 1,   0, 10'h000, 0, 32'h0);
    addv(0, 0, 32'h0,        0, 1,   0, 10'h000, 0, 32'h0);
    // streaming from reset
    addv(1, 0, 32'h0,        0, 1,   1, 10'h000, 0, 32'h0);
    addv(1, 0, 32'h0,        0, 1,   1, 10'h001, 0, 32'h0);
    addv(1, 0, 32'h0,        0, 1,   1, 10'h002, 1, 32'h0);
    addv(1, 0, 32'h0,        0, 1,   1, 10'h003, 1, 32'h1);
    addv(1, 0, 32'h0,        0, 1,   1, 10'h004, 1, 32'h2);
    // backpressure for 3 cycles
    addv(1, 0, 32'h0,        0, 0,   0, 10'h005, 1, 32'h3);
    addv(1, 0, 32'h0,        0, 0,   0, 10'h005, 1, 32'h3);
    addv(1, 0, 32'h0,        0, 0,   0, 10'h005, 1, 32'h3);
    addv(1, 0, 32'h0,        0, 1,   0, 10'h005, 1, 32'h3);
    addv(1, 0, 32'h0,        0, 1,   1, 10'h005, 1, 32'h4);
    addv(1, 0, 32'h0,        0, 1,   1, 10'h006, 0, 32'h4);
    addv(1, 0, 32'h0,        0, 1,   1, 10'h007, 1, 32'h5);
    // redirect to 0x40 with read of 7 pending, together with a transfer of 6
    addv(1, 1, 32'h40,       0, 1,   0, 10'h008, 1, 32'h6);
    addv(1, 0, 32'h0,        0, 1,   1, 10'h040, 0, 32'h0);
    addv(1, 0, 32'h0,        0, 1,   1, 10'h041, 0, 32'h0);
    addv(1, 0, 32'h0,        0, 1,   1, 10'h042, 1, 32'h40);
    // halt with 0x42 in flight; it is still delivered
    addv(1, 0, 32'h0,        1, 1,   0, 10'h043, 1, 32'h41);
    addv(1, 0, 32'h0,        0, 1,   0, 10'h043, 1, 32'h42);
    addv(1, 0, 32'h0,        0, 1,   0, 10'h043, 0, 32'h0);
    addv(1, 0, 32'h0,        1, 1,   0, 10'h043, 0, 32'h0);
    // redirect and halt together: redirect wins
    addv(1, 1, 32'h10,       1, 1,   0, 10'h043, 0, 32'h0);
    addv(1, 0, 32'h0,        0, 1,   1, 10'h010, 0, 32'h0);
    addv(1, 0, 32'h0,        0, 1,   1, 10'h011, 0, 32'h0);
    addv(1, 0, 32'h0,        0, 1,   1, 10'h012, 1, 32'h10);
    // redirect near the top of the PC space to exercise the wrap
    addv(1, 1, 32'hFFFF_FFFE, 0, 1,  0, 10'h013, 1, 32'h11);
    addv(1, 0, 32'h0,        0, 1,   1, 10'h3FE, 0, 32'h0);
    addv(1, 0, 32'h0,        0, 1,   1, 10'h3FF, 0, 32'h0);
    addv(1, 0, 32'h0,        0, 1,   1, 10'h000, 1, 32'hFFFF_FFFE);
    addv(1, 0, 32'h0,        0, 1,   1, 10'h001, 1, 32'hFFFF_FFFF);
    addv(1, 0, 32'h0,        0, 1,   1, 10'h002, 1, 32'h0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].rv, vecs[i].rpc, vecs[i].hlt, vecs[i].rdy);
      check($sformatf("vec%0d_mem_en", i), {31'b0, bus.mem_en}, {31'b0, vecs[i].exp_en});
      check($sformatf("vec%0d_mem_addr", i), {22'b0, bus.mem_addr}, {22'b0, vecs[i].exp_addr});
      check($sformatf("vec%0d_inst_valid", i), {31'b0, bus.inst_valid}, {31'b0, vecs[i].exp_iv});
      if (vecs[i].exp_iv) begin
        check($sformatf("vec%0d_inst_pc", i), bus.inst_pc, vecs[i].exp_ipc);
        check($sformatf("vec%0d_inst_out", i), bus.inst_out, rom_word(vecs[i].exp_ipc[AW-1:0]));
      end
      if (!vecs[i].rst) begin
        check($sformatf("vec%0d_rst_inst_pc", i), bus.inst_pc, 32'h0);
        check($sformatf("vec%0d_rst_inst_out", i), bus.inst_out, 32'h0);
      end
    end

    // Fill the skid, then drop reset asynchronously mid-cycle
    drive(1, 0, 32'h0, 0, 0);
    check("stall1_mem_en", {31'b0, bus.mem_en}, 32'h0);
    check("stall1_inst_pc", bus.inst_pc, 32'h1);
    drive(1, 0, 32'h0, 0, 0);
    check("stall2_mem_en", {31'b0, bus.mem_en}, 32'h0);
    check("stall2_inst_valid", {31'b0, bus.inst_valid}, 32'h1);
    check("stall2_inst_out", bus.inst_out, rom_word(10'h001));
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_inst_valid", {31'b0, bus.inst_valid}, 32'h0);
    check("async_rst_inst_out", bus.inst_out, 32'h0);
    check("async_rst_inst_pc", bus.inst_pc, 32'h0);
    check("async_rst_mem_en", {31'b0, bus.mem_en}, 32'h0);
    drive(0, 0, 32'h0, 0, 1);
    drive(1, 0, 32'h0, 0, 1);
    check("restart_mem_en", {31'b0, bus.mem_en}, 32'h1);
    check("restart_addr0", {22'b0, bus.mem_addr}, 32'h0);
    drive(1, 0, 32'h0, 0, 1);
    check("restart_addr1", {22'b0, bus.mem_addr}, 32'h1);
    drive(1, 0, 32'h0, 0, 1);
    check("restart_inst_valid", {31'b0, bus.inst_valid}, 32'h1);
    check("restart_inst_pc", bus.inst_pc, 32'h0);
    check("restart_inst_out", bus.inst_out, rom_word(10'h000));

    // Randomized run against the stream model
    drive(0, 0, 32'h0, 0, 0);
    exp_issue_pc   = 32'h0;
    exp_deliver_pc = 32'h0;
    model_halted   = 1'b0;
    prev_stall     = 1'b0;
    prev_ipc       = '0;
    prev_iout      = '0;
    delivered      = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      logic        rv, hlt, rdy;
      logic [31:0] rpc;
      rv  = ($urandom_range(99) < 3);
      hlt = ($urandom_range(99) < 3);
      rdy = ($urandom_range(99) < 70);
      rpc = ($urandom_range(3) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(3))) : $urandom;
      drive(1, rv, rpc, hlt, rdy);

      if (prev_stall) begin
        check("rnd_hold_valid", {31'b0, bus.inst_valid}, 32'h1);
        check("rnd_hold_pc", bus.inst_pc, prev_ipc);
        check("rnd_hold_out", bus.inst_out, prev_iout);
      end
      if (bus.mem_en) begin
        check("rnd_issue_addr", {22'b0, bus.mem_addr}, {22'b0, exp_issue_pc[AW-1:0]});
        check("rnd_issue_gate", {31'b0, (model_halted || rv || hlt)}, 32'h0);
      end
      if (bus.inst_valid && rdy) begin
        check("rnd_deliver_pc", bus.inst_pc, exp_deliver_pc);
        check("rnd_deliver_out", bus.inst_out, rom_word(exp_deliver_pc[AW-1:0]));
      end

      prev_stall = bus.inst_valid && !rdy && !rv;
      prev_ipc   = bus.inst_pc;
      prev_iout  = bus.inst_out;
      if (bus.mem_en) exp_issue_pc = exp_issue_pc + 32'd1;
      if (bus.inst_valid && rdy) begin
        exp_deliver_pc = exp_deliver_pc + 32'd1;
        delivered++;
      end
      if (rv) begin
        exp_issue_pc   = rpc;
        exp_deliver_pc = rpc;
        model_halted   = 1'b0;
      end else if (hlt) begin
        model_halted = 1'b1;
      end
    end
    check("rnd_progress", {31'b0, (delivered >= 200)}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
